// File: rtl/uart_pkg.sv
// Shared types and constants for the wireless-hangman UART pair (uart_tx / uart_rx).
package uart_pkg;

  localparam int   FRAME_BITS = 11;
  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5,
    BREAK  = 3'd6
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Parity bit that makes data plus parity carry an even number of ones.
  function automatic logic even_parity_bit(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: the serial line in, the delivered byte and its status out.
// The master modport is the receiver itself; the slave modport is the line driver / game logic.
interface uart_rx_if;

  logic       rx_serial;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       parity_err;
  logic       framing_err;
  logic       rx_busy;

  modport master (
    input  rx_serial,
    output rx_byte,
    output rx_valid,
    output parity_err,
    output framing_err,
    output rx_busy
  );

  modport slave (
    output rx_serial,
    input  rx_byte,
    input  rx_valid,
    input  parity_err,
    input  framing_err,
    input  rx_busy
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RESET_VAL so an idle line does not look like an edge after reset.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic nRst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops before anything else looks at it.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, even-parity bit, stop.
// Each bit is sampled once, at mid-bit, from the synchronised line.
// Bytes with parity or framing errors are still delivered; the flags tell the consumer.
// Clkperbaud must be at least 4 and match the transmitter.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Clkperbaud = 1250
) (
  input  logic      clk,
  input  logic      nRst,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(Clkperbaud);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(Clkperbaud / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(Clkperbaud - 1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] clk_count;
  logic [2:0]       bit_index;
  logic [7:0]       shift_reg;
  logic             par_bit;
  logic             stop_bit;
  logic             rx_s;

  logic [7:0]       rx_byte_q;
  logic             rx_valid_q;
  logic             parity_err_q;
  logic             framing_err_q;

  logic             half_done;
  logic             count_done;
  logic             counting;

  sync2 #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk  (clk),
    .nRst (nRst),
    .d    (bus.rx_serial),
    .q    (rx_s)
  );

  assign half_done  = (clk_count == HALF_LAST);
  assign count_done = (clk_count == BIT_LAST);
  assign counting   = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);

  // State register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; a held-low line after a bad stop parks in BREAK instead of re-arming.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
        end
      end
      START: begin
        if (half_done) begin
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (count_done && (bit_index == IDX_LAST)) begin
          state_next = PARITY;
        end
      end
      PARITY: begin
        if (count_done) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (count_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = stop_bit ? IDLE : BREAK;
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Baud and bit counters: cleared on every state change, never counting past the bit end.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      clk_count <= '0;
      bit_index <= '0;
    end else if (state_next != state) begin
      clk_count <= '0;
      bit_index <= '0;
    end else if ((state == DATA) && count_done) begin
      clk_count <= '0;
      bit_index <= bit_index + 3'd1;
    end else if (counting && !count_done) begin
      clk_count <= clk_count + CNT_W'(1);
    end
  end

  // Mid-bit sampling of data, parity and stop bits.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      shift_reg <= '0;
      par_bit   <= 1'b0;
      stop_bit  <= 1'b0;
    end else if (count_done) begin
      case (state)
        DATA:    shift_reg[bit_index] <= rx_s;
        PARITY:  par_bit              <= rx_s;
        STOP:    stop_bit             <= rx_s;
        default: ;
      endcase
    end
  end

  // Result registers load on the edge into DONE, so rx_valid and the new byte/flags appear together.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_byte_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if ((state == STOP) && count_done) begin
        rx_byte_q     <= shift_reg;
        rx_valid_q    <= 1'b1;
        parity_err_q  <= par_bit ^ even_parity_bit(shift_reg);
        framing_err_q <= ~rx_s;
      end
    end
  end

  assign bus.rx_byte     = rx_byte_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.framing_err = framing_err_q;
  assign bus.rx_busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with a 16-clock bit period.
// The line is driven bit by bit from the bench; expected bytes and flags are hand-computed.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLKS = 16;

  logic clk  = 1'b0;
  logic nRst = 1'b0;

  int checks = 0;
  int errors = 0;

  int         valid_count = 0;
  logic [7:0] cap_byte [0:15];
  logic       cap_perr [0:15];
  logic       cap_ferr [0:15];

  uart_rx_if bus ();

  uart_rx #(
    .Clkperbaud (CLKS)
  ) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Count every cycle rx_valid is high and record what was delivered with it.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      cap_byte[valid_count % 16] <= bus.rx_byte;
      cap_perr[valid_count % 16] <= bus.parity_err;
      cap_ferr[valid_count % 16] <= bus.framing_err;
      valid_count                <= valid_count + 1;
    end
  end

  task automatic drive_bit(input logic v, input int cycles);
    bus.rx_serial = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    logic [FRAME_BITS-1:0] frame;
    frame = {stop, par, data, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) begin
      drive_bit(frame[i], CLKS);
    end
  endtask

  task automatic test_reset();
    bus.rx_serial = 1'b1;
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.rx_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset_byte got %h exp 00", bus.rx_byte); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", bus.rx_valid); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr got %b exp 0", bus.parity_err); end
    checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr got %b exp 0", bus.framing_err); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", bus.rx_busy); end
    nRst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clean_byte();
    int base;
    base = valid_count;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    checks++; if (valid_count !== base + 1) begin errors++; $display("[TB] FAIL clean_strobes got %0d exp %0d", valid_count - base, 1); end
    checks++; if (cap_byte[base % 16] !== 8'hA5) begin errors++; $display("[TB] FAIL clean_cap_byte got %h exp a5", cap_byte[base % 16]); end
    checks++; if (bus.rx_byte !== 8'hA5) begin errors++; $display("[TB] FAIL clean_held_byte got %h exp a5", bus.rx_byte); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("[TB] FAIL clean_perr got %b exp 0", bus.parity_err); end
    checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("[TB] FAIL clean_ferr got %b exp 0", bus.framing_err); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL clean_busy got %b exp 0", bus.rx_busy); end
  endtask

  task automatic test_parity_error();
    int base;
    base = valid_count;
    send_frame(8'h01, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    checks++; if (valid_count !== base + 1) begin errors++; $display("[TB] FAIL par_strobes got %0d exp %0d", valid_count - base, 1); end
    checks++; if (bus.rx_byte !== 8'h01) begin errors++; $display("[TB] FAIL par_byte got %h exp 01", bus.rx_byte); end
    checks++; if (bus.parity_err !== 1'b1) begin errors++; $display("[TB] FAIL par_perr got %b exp 1", bus.parity_err); end
    checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("[TB] FAIL par_ferr got %b exp 0", bus.framing_err); end
  endtask

  task automatic test_framing_break();
    int base;
    base = valid_count;
    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b0, 40);
    checks++; if (valid_count !== base + 1) begin errors++; $display("[TB] FAIL brk_strobes got %0d exp %0d", valid_count - base, 1); end
    checks++; if (bus.rx_byte !== 8'h3C) begin errors++; $display("[TB] FAIL brk_byte got %h exp 3c", bus.rx_byte); end
    checks++; if (bus.framing_err !== 1'b1) begin errors++; $display("[TB] FAIL brk_ferr got %b exp 1", bus.framing_err); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("[TB] FAIL brk_perr got %b exp 0", bus.parity_err); end
    checks++; if (bus.rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL brk_busy_low got %b exp 1", bus.rx_busy); end
    drive_bit(1'b1, 6);
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL brk_busy_release got %b exp 0", bus.rx_busy); end
    drive_bit(1'b1, 30);
    checks++; if (valid_count !== base + 1) begin errors++; $display("[TB] FAIL brk_no_retrigger got %0d exp %0d", valid_count - base, 1); end
  endtask

  task automatic test_glitch();
    int base;
    base = valid_count;
    drive_bit(1'b0, 3);
    drive_bit(1'b1, CLKS / 2 + 3);
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy got %b exp 0", bus.rx_busy); end
    drive_bit(1'b1, 20);
    checks++; if (valid_count !== base) begin errors++; $display("[TB] FAIL glitch_strobes got %0d exp 0", valid_count - base); end
    checks++; if (bus.rx_byte !== 8'h3C) begin errors++; $display("[TB] FAIL glitch_byte got %h exp 3c", bus.rx_byte); end
    checks++; if (bus.framing_err !== 1'b1) begin errors++; $display("[TB] FAIL glitch_ferr got %b exp 1", bus.framing_err); end
  endtask

  task automatic test_back_to_back();
    int         base;
    logic [7:0] exp_bytes [0:2];
    exp_bytes[0] = 8'h00;
    exp_bytes[1] = 8'hFF;
    exp_bytes[2] = 8'h5A;
    base = valid_count;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    checks++; if (valid_count !== base + 3) begin errors++; $display("[TB] FAIL b2b_strobes got %0d exp %0d", valid_count - base, 3); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (cap_byte[(base + k) % 16] !== exp_bytes[k]) begin errors++; $display("[TB] FAIL b2b_byte%0d got %h exp %h", k, cap_byte[(base + k) % 16], exp_bytes[k]); end
      checks++; if (cap_perr[(base + k) % 16] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_perr%0d got %b exp 0", k, cap_perr[(base + k) % 16]); end
      checks++; if (cap_ferr[(base + k) % 16] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ferr%0d got %b exp 0", k, cap_ferr[(base + k) % 16]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = valid_count;
    drive_bit(1'b0, CLKS);
    drive_bit(1'b0, CLKS);
    drive_bit(1'b1, CLKS);
    drive_bit(1'b1, CLKS);
    drive_bit(1'b1, CLKS);
    drive_bit(1'b1, CLKS / 2);
    nRst = 1'b0;
    #1;
    checks++; if (bus.rx_byte !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_byte got %h exp 00", bus.rx_byte); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got %b exp 0", bus.rx_valid); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_perr got %b exp 0", bus.parity_err); end
    checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ferr got %b exp 0", bus.framing_err); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy got %b exp 0", bus.rx_busy); end
    bus.rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    nRst = 1'b1;
    repeat (3 * CLKS) @(negedge clk);
    checks++; if (valid_count !== base) begin errors++; $display("[TB] FAIL mid_rst_strobes got %0d exp 0", valid_count - base); end
    send_frame(8'h7E, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    checks++; if (valid_count !== base + 1) begin errors++; $display("[TB] FAIL after_rst_strobes got %0d exp %0d", valid_count - base, 1); end
    checks++; if (bus.rx_byte !== 8'h7E) begin errors++; $display("[TB] FAIL after_rst_byte got %h exp 7e", bus.rx_byte); end
    checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("[TB] FAIL after_rst_perr got %b exp 0", bus.parity_err); end
    checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("[TB] FAIL after_rst_ferr got %b exp 0", bus.framing_err); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    bus.rx_serial = 1'b1;
    test_reset();
    test_clean_byte();
    test_parity_error();
    test_framing_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
